// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Shares one AXI4 read master among NUM_REQ read requesters. AR requests are
//   granted round-robin into a single registered AR slot; the owner index of
//   every accepted burst is queued in an in-order tracking FIFO so that R beats
//   (single ID, hence in order) are steered to the oldest outstanding owner
//   until rlast.
//
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   s_axi_ar{valid,ready}      per-requester AR handshake (bit i = requester i)
//   s_axi_ar{addr,len}         per-requester AR fields (slice i = requester i)
//   s_axi_r{data,resp}         R data/response, broadcast to all requesters
//   s_axi_r{valid,last}        R valid/last, only the owning requester's bit set
//   s_axi_rready               per-requester R ready
//   m_axi_ar*                  registered AXI4 AR master channel
//   m_axi_r*                   AXI4 R master channel
module axi_rd_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 48,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int MAX_OUTSTANDING    = 8
) (
    input  logic                                  clk,
    input  logic                                  rstn,

    input  logic [NUM_REQ-1:0]                    s_axi_arvalid,
    output logic [NUM_REQ-1:0]                    s_axi_arready,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [NUM_REQ*8-1:0]                  s_axi_arlen,
    output logic [C_M_AXI_DATA_WIDTH-1:0]         s_axi_rdata,
    output logic [1:0]                            s_axi_rresp,
    output logic [NUM_REQ-1:0]                    s_axi_rlast,
    output logic [NUM_REQ-1:0]                    s_axi_rvalid,
    input  logic [NUM_REQ-1:0]                    s_axi_rready,

    output logic [C_M_AXI_ID_WIDTH-1:0]           m_axi_arid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                            m_axi_arlen,
    output logic [2:0]                            m_axi_arsize,
    output logic [1:0]                            m_axi_arburst,
    output logic                                  m_axi_arlock,
    output logic [3:0]                            m_axi_arcache,
    output logic [2:0]                            m_axi_arprot,
    output logic [3:0]                            m_axi_arqos,
    output logic                                  m_axi_arvalid,
    input  logic                                  m_axi_arready,

    input  logic [C_M_AXI_ID_WIDTH-1:0]           m_axi_rid,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                            m_axi_rresp,
    input  logic                                  m_axi_rlast,
    input  logic                                  m_axi_rvalid,
    output logic                                  m_axi_rready
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]              last_grant;
    logic [IDX_W-1:0]              winner;
    logic                          found;
    logic [C_M_AXI_ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]                    sel_len;
    logic                          slot_free;
    logic                          grant;
    logic                          pop;

    logic [IDX_W-1:0]              fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [CNT_W-1:0]              count;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [IDX_W-1:0]              head;

    // Single-ID design: the returned ID carries no routing information.
    logic                          unused_rid;
    assign unused_rid = ^m_axi_rid;

    assign m_axi_arid    = '0;
    assign m_axi_arsize  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0010;
    assign m_axi_arprot  = '0;
    assign m_axi_arqos   = '0;

    assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign slot_free  = ~m_axi_arvalid | m_axi_arready;

    // Round-robin pick: first asserted requester scanning up from last_grant+1.
    always_comb begin
        int unsigned cand;
        winner = last_grant;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(last_grant) + i) % NUM_REQ;
            if (!found && s_axi_arvalid[cand]) begin
                winner = IDX_W'(cand);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == winner) begin
                sel_addr = s_axi_araddr[i*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
                sel_len  = s_axi_arlen[i*8 +: 8];
            end
        end
    end

    // Full is judged on the registered count, so a pop in the same cycle does
    // not free a slot until the following cycle.
    assign grant = rstn & slot_free & ~fifo_full & found;

    always_comb begin
        s_axi_arready = '0;
        if (grant) begin
            s_axi_arready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            last_grant    <= IDX_W'(NUM_REQ - 1);
        end else if (grant) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= sel_addr;
            m_axi_arlen   <= sel_len;
            last_grant    <= winner;
        end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
        end
    end

    // Tracking FIFO of burst owners.
    always_ff @(posedge clk) begin
        if (grant) begin
            fifo_mem[wr_ptr] <= winner;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (grant) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // R routing: pure combinational steering to the head owner.
    assign s_axi_rdata = m_axi_rdata;
    assign s_axi_rresp = m_axi_rresp;

    always_comb begin
        m_axi_rready = rstn & ~fifo_empty & s_axi_rready[head];
        s_axi_rvalid = '0;
        s_axi_rlast  = '0;
        if (!fifo_empty) begin
            s_axi_rvalid[head] = m_axi_rvalid;
            s_axi_rlast[head]  = m_axi_rlast;
        end
    end

    assign pop = m_axi_rvalid & m_axi_rready & m_axi_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

    localparam int NR = 4;
    localparam int AW = 48;
    localparam int DW = 32;
    localparam int IW = 1;

    logic              clk;
    logic              rstn;
    logic [NR-1:0]     s_axi_arvalid;
    logic [NR-1:0]     s_axi_arready;
    logic [NR*AW-1:0]  s_axi_araddr;
    logic [NR*8-1:0]   s_axi_arlen;
    logic [DW-1:0]     s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic [NR-1:0]     s_axi_rlast;
    logic [NR-1:0]     s_axi_rvalid;
    logic [NR-1:0]     s_axi_rready;
    logic [IW-1:0]     m_axi_arid;
    logic [AW-1:0]     m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arlock;
    logic [3:0]        m_axi_arcache;
    logic [2:0]        m_axi_arprot;
    logic [3:0]        m_axi_arqos;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [IW-1:0]     m_axi_rid;
    logic [DW-1:0]     m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    axi_rd_arbiter #(
        .NUM_REQ            (NR),
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_M_AXI_ID_WIDTH   (IW),
        .MAX_OUTSTANDING    (8)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arqos   (m_axi_arqos),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [NR-1:0] arvalid; logic [NR-1:0] exp_ready; } vec_t;
    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_exp_t;
    typedef struct { int owner; int beats; } r_exp_t;

    ar_exp_t aq[$];
    r_exp_t  rq[$];
    int      checks = 0;
    int      errors = 0;
    int      issued[NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l);
        s_axi_araddr[i*AW +: AW] = a;
        s_axi_arlen[i*8 +: 8]    = l;
    endtask

    function automatic logic [AW-1:0] tab_addr(input int i, input int k);
        return 48'h10000 * 48'(i + 1) + 48'(k * 64);
    endfunction

    function automatic logic [7:0] tab_len(input int i, input int k);
        return 8'(i + 4 * k);
    endfunction

    task automatic expect_grant(input int w, input logic [AW-1:0] a, input logic [7:0] l);
        ar_exp_t ae;
        r_exp_t  re;
        ae.addr  = a;
        ae.len   = l;
        re.owner = w;
        re.beats = int'(l) + 1;
        aq.push_back(ae);
        rq.push_back(re);
    endtask

    // Drives one whole R burst for the oldest expected burst, checking routing
    // on every beat. Leaves rvalid asserted after the final beat.
    task automatic r_burst();
        r_exp_t      e;
        logic [31:0] d;
        logic [63:0] owner_bit;
        if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL r_queue_empty: got no pending burst, expected one");
            return;
        end
        e = rq.pop_front();
        owner_bit = 64'(1) << e.owner;
        for (int b = 0; b < e.beats; b++) begin
            @(negedge clk);
            d = 32'hD000_0000 | (32'(e.owner) << 16) | 32'(b);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = d;
            m_axi_rresp  = 2'(b);
            m_axi_rlast  = (b == e.beats - 1);
            s_axi_rready = '1;
            #1;
            chk("r_valid_owner", 64'(s_axi_rvalid), owner_bit);
            chk("r_last_owner", 64'(s_axi_rlast), (b == e.beats - 1) ? owner_bit : 64'(0));
            chk("r_data", 64'(s_axi_rdata), 64'(d));
            chk("r_resp", 64'(s_axi_rresp), 64'(b % 4));
            chk("m_rready", 64'(m_axi_rready), 64'(1));
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // AR scoreboard: every master AR handshake must match the oldest expectation.
    always begin
        ar_exp_t ae;
        @(negedge clk);
        #2;
        if (rstn && m_axi_arvalid && m_axi_arready) begin
            if (aq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ar_unexpected: got addr 0x%0h, expected no handshake", m_axi_araddr);
            end else begin
                ae = aq.pop_front();
                chk("ar_addr", 64'(m_axi_araddr), 64'(ae.addr));
                chk("ar_len", 64'(m_axi_arlen), 64'(ae.len));
            end
        end
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL timeout: got no completion, expected finish");
        finish_sim();
    end

    initial begin
        vec_t vt[10];
        int   w;
        vt[0] = '{4'b0000, 4'b0000};
        vt[1] = '{4'b0100, 4'b0100};
        vt[2] = '{4'b0101, 4'b0001};
        vt[3] = '{4'b0100, 4'b0100};
        vt[4] = '{4'b1111, 4'b1000};
        vt[5] = '{4'b0111, 4'b0001};
        vt[6] = '{4'b0110, 4'b0010};
        vt[7] = '{4'b0100, 4'b0100};
        vt[8] = '{4'b1000, 4'b1000};
        vt[9] = '{4'b0001, 4'b0000};   // eight outstanding: blocked
        foreach (issued[i]) issued[i] = 0;

        // Reset values, with requests and R beats present during reset.
        rstn = 1'b0;
        s_axi_arvalid = '1;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_rready  = '1;
        m_axi_arready = 1'b0;
        m_axi_rid     = '0;
        m_axi_rdata   = '0;
        m_axi_rresp   = '0;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_arready", 64'(s_axi_arready), 64'(0));
        chk("rst_m_rready", 64'(m_axi_rready), 64'(0));
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
        chk("rst_araddr", 64'(m_axi_araddr), 64'(0));
        chk("rst_arlen", 64'(m_axi_arlen), 64'(0));
        chk("const_arid", 64'(m_axi_arid), 64'(0));
        chk("const_arsize", 64'(m_axi_arsize), 64'(2));
        chk("const_arburst", 64'(m_axi_arburst), 64'(1));
        chk("const_arcache", 64'(m_axi_arcache), 64'(2));
        chk("const_misc", 64'({m_axi_arlock, m_axi_arprot, m_axi_arqos}), 64'(0));

        @(negedge clk);
        rstn = 1'b1;
        s_axi_arvalid = '0;
        m_axi_rvalid  = 1'b0;
        m_axi_arready = 1'b1;

        // Round-robin table, filling the tracking FIFO to its depth.
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) set_req(i, tab_addr(i, issued[i]), tab_len(i, issued[i]));
            s_axi_arvalid = vt[r].arvalid;
            #1;
            chk($sformatf("rr_row%0d", r), 64'(s_axi_arready), 64'(vt[r].exp_ready));
            w = -1;
            for (int i = 0; i < NR; i++) if (vt[r].exp_ready[i]) w = i;
            if (w >= 0) begin
                expect_grant(w, tab_addr(w, issued[w]), tab_len(w, issued[w]));
                issued[w]++;
            end
        end

        // One rlast pop while full: grant only in the following cycle.
        r_burst();
        chk("full_blocks_during_pop", 64'(s_axi_arready), 64'(0));
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;
        chk("grant_after_pop", 64'(s_axi_arready), 64'(4'b0001));
        expect_grant(0, tab_addr(0, issued[0]), tab_len(0, issued[0]));
        issued[0]++;
        @(negedge clk);
        s_axi_arvalid = '0;

        // Drain back-to-back, owners changing without bubbles.
        while (rq.size() > 0) r_burst();

        // Beat with nothing outstanding is refused.
        @(negedge clk);
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        #1;
        chk("empty_m_rready", 64'(m_axi_rready), 64'(0));
        chk("empty_s_rvalid", 64'(s_axi_rvalid), 64'(0));

        // Single request from req2, AR held one cycle to observe the slot.
        @(negedge clk);
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_arready = 1'b0;
        set_req(2, 48'h1000, 8'd15);
        s_axi_arvalid = 4'b0100;
        #1;
        chk("single_grant", 64'(s_axi_arready), 64'(4'b0100));
        expect_grant(2, 48'h1000, 8'd15);
        @(negedge clk);
        s_axi_arvalid = '0;
        #1;
        chk("single_arvalid", 64'(m_axi_arvalid), 64'(1));
        chk("single_araddr", 64'(m_axi_araddr), 64'(48'h1000));
        chk("single_arlen", 64'(m_axi_arlen), 64'(15));
        @(negedge clk);
        m_axi_arready = 1'b1;
        // Owner not ready: beat held upstream.
        m_axi_rvalid  = 1'b1;
        m_axi_rlast   = 1'b0;
        s_axi_rready  = 4'b1011;
        #1;
        chk("stall_m_rready", 64'(m_axi_rready), 64'(0));
        chk("stall_s_rvalid", 64'(s_axi_rvalid), 64'(4'b0100));
        r_burst();
        @(negedge clk);
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        #1;
        chk("single_fifo_empty", 64'(m_axi_rready), 64'(0));

        // AR backpressure: req1 held in the slot, req3 waits.
        @(negedge clk);
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_arready = 1'b0;
        set_req(1, 48'h2000, 8'd3);
        s_axi_arvalid = 4'b0010;
        #1;
        chk("bp_grant_req1", 64'(s_axi_arready), 64'(4'b0010));
        expect_grant(1, 48'h2000, 8'd3);
        @(negedge clk);
        set_req(3, 48'h3000, 8'd5);
        s_axi_arvalid = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_no_arready", 64'(s_axi_arready), 64'(0));
            chk("bp_arvalid", 64'(m_axi_arvalid), 64'(1));
            chk("bp_araddr", 64'(m_axi_araddr), 64'(48'h2000));
            chk("bp_arlen", 64'(m_axi_arlen), 64'(3));
            @(negedge clk);
        end
        m_axi_arready = 1'b1;
        #1;
        chk("bp_release_grant", 64'(s_axi_arready), 64'(4'b1000));
        expect_grant(3, 48'h3000, 8'd5);
        @(negedge clk);
        set_req(0, 48'h4000, 8'd2);
        s_axi_arvalid = 4'b0001;
        #1;
        chk("third_grant", 64'(s_axi_arready), 64'(4'b0001));
        expect_grant(0, 48'h4000, 8'd2);
        @(negedge clk);
        s_axi_arvalid = '0;

        // Reset with three bursts outstanding.
        @(negedge clk);
        rstn = 1'b0;
        s_axi_arvalid = '1;
        aq.delete();
        rq.delete();
        #1;
        chk("midrst_arready", 64'(s_axi_arready), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 48'h5000 + 48'(i * 256), 8'(i));
        s_axi_arvalid = '1;
        m_axi_rvalid  = 1'b1;
        m_axi_rlast   = 1'b1;
        #1;
        chk("midrst_arvalid", 64'(m_axi_arvalid), 64'(0));
        chk("midrst_fifo_empty", 64'(m_axi_rready), 64'(0));
        chk("midrst_s_rvalid", 64'(s_axi_rvalid), 64'(0));
        chk("midrst_first_grant", 64'(s_axi_arready), 64'(4'b0001));
        expect_grant(0, 48'h5000, 8'd0);
        @(negedge clk);
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        s_axi_arvalid = 4'b1110;
        #1;
        chk("midrst_grant1", 64'(s_axi_arready), 64'(4'b0010));
        expect_grant(1, 48'h5100, 8'd1);
        @(negedge clk);
        s_axi_arvalid = 4'b1100;
        #1;
        chk("midrst_grant2", 64'(s_axi_arready), 64'(4'b0100));
        expect_grant(2, 48'h5200, 8'd2);
        @(negedge clk);
        s_axi_arvalid = 4'b1000;
        #1;
        chk("midrst_grant3", 64'(s_axi_arready), 64'(4'b1000));
        expect_grant(3, 48'h5300, 8'd3);
        @(negedge clk);
        s_axi_arvalid = '0;
        while (rq.size() > 0) r_burst();
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("ar_scoreboard_drained", 64'(aq.size()), 64'(0));
        finish_sim();
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares one AXI4 read master port among `NUM_REQ` read requesters in the SpMV kernel (column-index, value and x-vector fetch streams), ahead of the burst-aggregating read path. AR requests are granted round-robin and registered onto the master port. The requester index of each accepted burst is held in an in-order tracking FIFO. R beats are steered to the owner of the oldest outstanding burst until `rlast`. A single AXI ID (0) is used, so responses return in order.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requester ports (2..8)
- `C_M_AXI_ADDR_WIDTH`, 48, address width
- `C_M_AXI_DATA_WIDTH`, 32, data width
- `C_M_AXI_ID_WIDTH`, 1, ID width; driven as 0
- `MAX_OUTSTANDING`, 8, tracking FIFO depth (power of two)

Ports. Requester buses are packed, with requester i in slice i.
- `clk`  in  1  sole clock, rising edge
- `rstn`  in  1  reset, synchronous, active-low
- `s_axi_arvalid`  in  NUM_REQ  per-requester AR valid
- `s_axi_arready`  out  NUM_REQ  per-requester AR ready
- `s_axi_araddr`  in  NUM_REQ*ADDR  per-requester address
- `s_axi_arlen`  in  NUM_REQ*8  per-requester burst length minus 1
- `s_axi_rdata`  out  DATA  read data, broadcast to all requesters
- `s_axi_rresp`  out  2  response, broadcast
- `s_axi_rlast`  out  NUM_REQ  last beat, only the owner's bit set
- `s_axi_rvalid`  out  NUM_REQ  beat valid, only the owner's bit set
- `s_axi_rready`  in  NUM_REQ  per-requester R ready
- `m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arvalid`  out  standard AXI4 AR channel
- `m_axi_arready`  in  1
- `m_axi_rid/rdata/rresp/rlast/rvalid`  in  standard AXI4 R channel
- `m_axi_rready`  out  1

## Operation
- Constant AR fields:
  - `arid` = 0
  - `arsize` = log2(DATA/8)
  - `arburst` = 2'b01 (INCR)
  - `arlock` = 0
  - `arcache` = 4'b0010
  - `arprot` = 0
  - `arqos` = 0
- The AR slot is one register holding `araddr`, `arlen` and `arvalid`. The slot is free when `~m_axi_arvalid | m_axi_arready`.
- Grant condition: slot free AND tracking FIFO not full AND at least one `s_axi_arvalid` set.
- Winner selection: the first requester with `arvalid` set, scanning upward (with wrap) from `last_grant+1`.
- Ready and capture: `s_axi_arready` is combinational and one-hot, asserted only for the winner in the grant cycle. On that edge:
  - the slot loads the winner's address and length,
  - `last_grant` is updated,
  - the winner index is pushed into the tracking FIFO.
- Non-winners wait with no starvation: any requester asserting continuously is granted within `NUM_REQ` grants.
- The FIFO stores `clog2(NUM_REQ)`-bit indices, with `MAX_OUTSTANDING` entries and a count of width `clog2(MAX_OUTSTANDING)+1`.
- Push and pop in the same cycle leave the count unchanged.
- A full FIFO blocks grants even if a pop occurs in the same cycle; the grant is deferred one cycle.
- R routing (all combinational), with `head` = FIFO head index:
  - `m_axi_rready = ~fifo_empty & s_axi_rready[head]`
  - `s_axi_rvalid[head] = m_axi_rvalid & ~fifo_empty`
  - `s_axi_rlast[head] = m_axi_rlast`
  - all other bits of `s_axi_rvalid` and `s_axi_rlast` are 0
  - `s_axi_rdata` and `s_axi_rresp` pass straight through
- The FIFO pops on `m_axi_rvalid & m_axi_rready & m_axi_rlast`.
- R beats arriving while the FIFO is empty are an upstream protocol error. They are not accepted: `m_axi_rready` = 0.

## Timing
- Reset (`rstn` = 0 at an edge):
  - `m_axi_arvalid` = 0, `m_axi_araddr` = 0, `m_axi_arlen` = 0
  - FIFO pointers and count = 0
  - `last_grant` = NUM_REQ-1, so requester 0 has first priority
- Combinational outputs while in reset: `s_axi_arready` = 0 and `m_axi_rready` = 0.
- Reset asserted mid-burst discards all outstanding tracking state. The downstream is reset together with this block.
- AR latency: a grant at edge N gives `m_axi_arvalid` = 1 after edge N. `m_axi_arvalid` and the AR fields stay stable until `m_axi_arready`.
- Back-to-back throughput: with `m_axi_arready` held at 1, one grant per cycle.
- R path: zero-cycle combinational pass-through, with no bubble between bursts of different owners.
- `rlast` pop timing: the pop takes effect at the same edge as the beat. The next beat, in the following cycle, routes to the new head.
- Handshakes follow AXI: a requester must hold `arvalid` and its fields until it sees `arready`.

## Test plan
- **Single request.** After reset, req2 issues addr 0x1000, len 15 → `m_axi_arvalid` one cycle later with araddr 0x1000, arlen 15. 16 R beats go to req2 only, `s_axi_rlast[2]` on beat 16, FIFO empty afterwards.
- **Round-robin fairness.** All 4 requesters hold `arvalid` with `m_axi_arready` = 1 → grant order 0,1,2,3,0,1,… with one grant per cycle. R bursts return in the same order and each reaches its own requester.
- **AR backpressure.** `m_axi_arready` = 0 for 5 cycles with req1 granted → `araddr`/`arlen` stable and no further `s_axi_arready`. Release → the next grant in the cycle the slot frees.
- **FIFO full.** With `MAX_OUTSTANDING` = 8 and no R traffic, 8 grants are made; the 9th request sees `s_axi_arready` = 0. After one `rlast` pop, the grant occurs on the following cycle.
- **R stall and empty FIFO.** `s_axi_rready[head]` = 0 → `m_axi_rready` = 0 with data held upstream. `m_axi_rvalid` = 1 with the FIFO empty → `m_axi_rready` = 0 and all `s_axi_rvalid` = 0.
- **Reset mid-operation.** Assert `rstn` = 0 with 3 bursts outstanding → next cycle `m_axi_arvalid` = 0, FIFO empty, and requester 0 wins the first post-reset grant.
